// File: rtl/pipeline_ctrl_pkg.sv
// Shared CPU package: controller state encoding, register-address width and
// default divide latency / exception vector, plus the registered output bundle.
package pipeline_ctrl_pkg;

  localparam int          REG_W          = 5;
  localparam int          DEF_DIV_CYCLES = 32;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_F000;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_DIV_WAIT  = 2'd1,
    ST_EXC_FLUSH = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic        pc_stall;
    logic        if_id_stall;
    logic        id_ex_stall;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_flush;
    logic        pc_redirect;
    logic [31:0] pc_redirect_addr;
    logic        cp0_exc_write;
    logic        div_busy;
  } ctrl_out_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: the load in EX writes a register the ID instruction reads.
// Register 0 is hardwired, so a load targeting it never creates a hazard.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_uses_rs,
  input  logic             i_id_uses_rt,
  input  logic             i_ex_load,
  input  logic [REG_W-1:0] i_ex_waddr,
  output logic             o_hazard
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = i_id_uses_rs && (i_id_rs == i_ex_waddr);
  assign w_rt_match = i_id_uses_rt && (i_id_rt == i_ex_waddr);
  assign o_hazard   = i_ex_load && (i_ex_waddr != '0) && (w_rs_match || w_rt_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/flush controller: exceptions, ERET, taken branches, multi-cycle
// divide and load-use stalls. Every output is a flop so the async flush clears stay glitch-free.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int          DIV_CYCLES = DEF_DIV_CYCLES,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_load,
  input  logic [REG_W-1:0] ex_waddr,
  input  logic             ex_div,
  input  logic             mem_exc,
  input  logic             mem_eret,
  input  logic             mem_branch_taken,
  input  logic [31:0]      mem_branch_target,
  input  logic [31:0]      epc,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             pc_redirect,
  output logic [31:0]      pc_redirect_addr,
  output logic             cp0_exc_write,
  output logic             div_busy
);

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  ctrl_state_e   r_state;
  ctrl_state_e   w_state_next;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          r_div_ack;
  logic          w_div_ack_next;
  ctrl_out_t     r_out;
  ctrl_out_t     w_out_raw;
  ctrl_out_t     w_out_next;
  logic          w_load_use;

  hazard_detect u_hazard_detect (
    .i_id_rs      (id_rs),
    .i_id_rt      (id_rt),
    .i_id_uses_rs (id_uses_rs),
    .i_id_uses_rt (id_uses_rt),
    .i_ex_load    (ex_load),
    .i_ex_waddr   (ex_waddr),
    .o_hazard     (w_load_use)
  );

  always_comb begin
    w_state_next   = (r_state == ST_DIV_WAIT) ? ST_DIV_WAIT : ST_RUN;
    w_count_next   = r_count;
    w_div_ack_next = 1'b0;
    w_out_raw      = '0;

    if (mem_exc || mem_eret) begin
      // Both discard any in-flight divide and spend one extra cycle flushing.
      w_out_raw.if_id_flush      = 1'b1;
      w_out_raw.id_ex_flush      = 1'b1;
      w_out_raw.ex_mem_flush     = 1'b1;
      w_out_raw.pc_redirect      = 1'b1;
      w_out_raw.pc_redirect_addr = mem_exc ? EXC_VECTOR : epc;
      w_out_raw.cp0_exc_write    = mem_exc;
      w_state_next               = ST_EXC_FLUSH;
      w_count_next               = '0;
    end else if (mem_branch_taken) begin
      w_out_raw.if_id_flush      = 1'b1;
      w_out_raw.id_ex_flush      = 1'b1;
      w_out_raw.ex_mem_flush     = 1'b1;
      w_out_raw.pc_redirect      = 1'b1;
      w_out_raw.pc_redirect_addr = mem_branch_target;
    end else begin
      case (r_state)
        ST_EXC_FLUSH: begin
          w_out_raw.if_id_flush  = 1'b1;
          w_out_raw.id_ex_flush  = 1'b1;
          w_out_raw.ex_mem_flush = 1'b1;
          w_state_next           = ST_RUN;
        end
        ST_DIV_WAIT: begin
          if (r_count == '0) begin
            // Ack masks the still-present ex_div for one cycle so it is not restarted.
            w_state_next   = ST_RUN;
            w_div_ack_next = 1'b1;
          end else begin
            w_out_raw.pc_stall     = 1'b1;
            w_out_raw.if_id_stall  = 1'b1;
            w_out_raw.id_ex_stall  = 1'b1;
            w_out_raw.ex_mem_flush = 1'b1;
            w_out_raw.div_busy     = 1'b1;
            w_count_next           = r_count - CW'(1);
          end
        end
        default: begin
          if (ex_div && !r_div_ack) begin
            w_out_raw.pc_stall     = 1'b1;
            w_out_raw.if_id_stall  = 1'b1;
            w_out_raw.id_ex_stall  = 1'b1;
            w_out_raw.ex_mem_flush = 1'b1;
            w_out_raw.div_busy     = 1'b1;
            w_state_next           = ST_DIV_WAIT;
            w_count_next           = CW'(DIV_CYCLES - 1);
          end else if (w_load_use) begin
            w_out_raw.pc_stall    = 1'b1;
            w_out_raw.if_id_stall = 1'b1;
            w_out_raw.id_ex_flush = 1'b1;
          end
        end
      endcase
    end

    // A flush always wins over a stall of the same register.
    w_out_next             = w_out_raw;
    w_out_next.if_id_stall = w_out_raw.if_id_stall & ~w_out_raw.if_id_flush;
    w_out_next.id_ex_stall = w_out_raw.id_ex_stall & ~w_out_raw.id_ex_flush;
    if (!w_out_raw.pc_redirect) begin
      w_out_next.pc_redirect_addr = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_count   <= '0;
      r_div_ack <= 1'b0;
      r_out     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_count   <= w_count_next;
      r_div_ack <= w_div_ack_next;
      r_out     <= w_out_next;
    end
  end

  assign pc_stall         = r_out.pc_stall;
  assign if_id_stall      = r_out.if_id_stall;
  assign id_ex_stall      = r_out.id_ex_stall;
  assign if_id_flush      = r_out.if_id_flush;
  assign id_ex_flush      = r_out.id_ex_flush;
  assign ex_mem_flush     = r_out.ex_mem_flush;
  assign pc_redirect      = r_out.pc_redirect;
  assign pc_redirect_addr = r_out.pc_redirect_addr;
  assign cp0_exc_write    = r_out.cp0_exc_write;
  assign div_busy         = r_out.div_busy;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: inputs change on the falling edge, outputs
// are checked on the next falling edge against hand-derived control patterns.
module tb_pipeline_ctrl;

  // {pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, ex_mem_flush,
  //  pc_redirect, cp0_exc_write, div_busy}
  localparam logic [8:0] P_IDLE = 9'b000_000_000;
  localparam logic [8:0] P_LU   = 9'b110_010_000;
  localparam logic [8:0] P_DIV  = 9'b111_001_001;
  localparam logic [8:0] P_EXC  = 9'b000_111_110;
  localparam logic [8:0] P_RDR  = 9'b000_111_100;
  localparam logic [8:0] P_FL   = 9'b000_111_000;

  logic        clock;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_waddr;
  logic        id_uses_rs, id_uses_rt, ex_load, ex_div;
  logic        mem_exc, mem_eret, mem_branch_taken;
  logic [31:0] mem_branch_target, epc;
  logic        pc_stall, if_id_stall, id_ex_stall;
  logic        if_id_flush, id_ex_flush, ex_mem_flush;
  logic        pc_redirect, cp0_exc_write, div_busy;
  logic [31:0] pc_redirect_addr;
  logic [8:0]  ctl;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_ctrl dut (
    .clock             (clock),
    .reset             (reset),
    .id_rs             (id_rs),
    .id_rt             (id_rt),
    .id_uses_rs        (id_uses_rs),
    .id_uses_rt        (id_uses_rt),
    .ex_load           (ex_load),
    .ex_waddr          (ex_waddr),
    .ex_div            (ex_div),
    .mem_exc           (mem_exc),
    .mem_eret          (mem_eret),
    .mem_branch_taken  (mem_branch_taken),
    .mem_branch_target (mem_branch_target),
    .epc               (epc),
    .pc_stall          (pc_stall),
    .if_id_stall       (if_id_stall),
    .id_ex_stall       (id_ex_stall),
    .if_id_flush       (if_id_flush),
    .id_ex_flush       (id_ex_flush),
    .ex_mem_flush      (ex_mem_flush),
    .pc_redirect       (pc_redirect),
    .pc_redirect_addr  (pc_redirect_addr),
    .cp0_exc_write     (cp0_exc_write),
    .div_busy          (div_busy)
  );

  assign ctl = {pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush,
                ex_mem_flush, pc_redirect, cp0_exc_write, div_busy};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [8:0] exp_ctl, input logic [31:0] exp_addr);
    check({tag, "/ctl"}, {23'd0, ctl}, {23'd0, exp_ctl});
    check({tag, "/addr"}, pc_redirect_addr, exp_addr);
    $display("step %-14s ctl=%b addr=%h", tag, ctl, pc_redirect_addr);
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_load = 1'b0; ex_waddr = '0; ex_div = 1'b0;
    mem_exc = 1'b0; mem_eret = 1'b0; mem_branch_taken = 1'b0;
    mem_branch_target = '0; epc = '0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    @(posedge clock);
    #1 check_out("reset", P_IDLE, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    tick(); check_out("idle", P_IDLE, 32'h0);

    // Load-use on rs, exactly one cycle
    ex_load = 1'b1; ex_waddr = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    tick(); check_out("lu_rs", P_LU, 32'h0);
    ex_load = 1'b0;
    tick(); check_out("lu_rs_after", P_IDLE, 32'h0);

    // Load-use on rt, then on both operands
    clear_inputs();
    ex_load = 1'b1; ex_waddr = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
    tick(); check_out("lu_rt", P_LU, 32'h0);
    id_rs = 5'd5;
    tick(); check_out("lu_both", P_LU, 32'h0);
    ex_load = 1'b0;
    tick(); check_out("lu_both_after", P_IDLE, 32'h0);

    // Match but operand unused, r0 target, non-load
    clear_inputs();
    ex_load = 1'b1; ex_waddr = 5'd9; id_rs = 5'd9; id_uses_rs = 1'b0;
    tick(); check_out("lu_unused", P_IDLE, 32'h0);
    ex_waddr = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    tick(); check_out("lu_r0", P_IDLE, 32'h0);
    ex_load = 1'b0; ex_waddr = 5'd9; id_rs = 5'd9;
    tick(); check_out("no_load", P_IDLE, 32'h0);

    // Divide held: 32 stall cycles then low on cycle 33
    clear_inputs();
    ex_div = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick(); check_out($sformatf("div_%0d", i), P_DIV, 32'h0);
    end
    tick(); check_out("div_33", P_IDLE, 32'h0);
    ex_div = 1'b0;
    tick(); check_out("div_done", P_IDLE, 32'h0);

    // Exception while the divide counter sits at 10
    ex_div = 1'b1;
    tick(); check_out("div2_start", P_DIV, 32'h0);
    for (int i = 0; i < 21; i++) tick();
    check_out("div2_cnt10", P_DIV, 32'h0);
    mem_exc = 1'b1;
    tick(); check_out("exc", P_EXC, 32'h0000_F000);
    mem_exc = 1'b0; ex_div = 1'b0;
    tick(); check_out("exc_flush", P_FL, 32'h0);
    tick(); check_out("exc_done", P_IDLE, 32'h0);

    // ERET
    epc = 32'h0000_0124; mem_eret = 1'b1;
    tick(); check_out("eret", P_RDR, 32'h0000_0124);
    mem_eret = 1'b0;
    tick(); check_out("eret_flush", P_FL, 32'h0);
    tick(); check_out("eret_done", P_IDLE, 32'h0);

    // Branch beats a simultaneous load-use hazard
    clear_inputs();
    mem_branch_taken = 1'b1; mem_branch_target = 32'h0000_0040;
    ex_load = 1'b1; ex_waddr = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1;
    tick(); check_out("branch_lu", P_RDR, 32'h0000_0040);
    clear_inputs();
    tick(); check_out("branch_done", P_IDLE, 32'h0);

    // Priority: exception over ERET over branch
    mem_exc = 1'b1; mem_eret = 1'b1; mem_branch_taken = 1'b1;
    mem_branch_target = 32'h0000_0080; epc = 32'h0000_0200;
    tick(); check_out("prio_exc", P_EXC, 32'h0000_F000);
    mem_exc = 1'b0;
    tick(); check_out("prio_eret", P_RDR, 32'h0000_0200);
    clear_inputs();
    tick(); check_out("prio_flush", P_FL, 32'h0);
    tick(); check_out("prio_done", P_IDLE, 32'h0);

    // Reset pulse in DIV_WAIT clears outputs without a clock edge
    ex_div = 1'b1;
    tick(); tick(); check_out("div3", P_DIV, 32'h0);
    #2 reset = 1'b1;
    #1 check_out("async_reset", P_IDLE, 32'h0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0; ex_div = 1'b0;
    tick(); check_out("post_reset", P_IDLE, 32'h0);
    ex_div = 1'b1;
    tick(); check_out("post_reset_div", P_DIV, 32'h0);
    ex_div = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 32, the number of cycles a DIV/DIVU occupies EX.
REQ-002 SHALL have parameter EXC_VECTOR, default 32'h0000_F000, the exception handler entry address.
REQ-003 SHALL have port clock, input, 1, rising-edge state clock (pipeline registers capture on falling edge).
REQ-004 SHALL have port reset, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have ports id_rs and id_rt, input, 5 each, source registers of the instruction in ID.
REQ-006 SHALL have ports id_uses_rs and id_uses_rt, input, 1 each, set when the ID instruction reads that operand.
REQ-007 SHALL have port ex_load, input, 1, the EX instruction is a memory or IO read.
REQ-008 SHALL have port ex_waddr, input, 5, destination register of the EX instruction.
REQ-009 SHALL have port ex_div, input, 1, the EX instruction is DIV or DIVU.
REQ-010 SHALL have ports mem_exc and mem_eret, input, 1 each: the MEM instruction raised an exception (overflow, divide-zero, syscall, break, reserved) / is ERET.
REQ-011 SHALL have ports mem_branch_taken (1) and mem_branch_target (32), input, the resolved branch or jump in MEM.
REQ-012 SHALL have port epc, input, 32, current CP0 EPC.
REQ-013 SHALL have outputs pc_stall, if_id_stall, id_ex_stall, 1 each: hold that register.
REQ-014 SHALL have outputs if_id_flush, id_ex_flush, ex_mem_flush, 1 each: bubble that register.
REQ-015 SHALL have outputs pc_redirect (1) and pc_redirect_addr (32): load the PC with the address.
REQ-016 SHALL have outputs cp0_exc_write (1), a pulse committing EPC/Cause, and div_busy (1).

Function
REQ-017 SHALL register every output on the rising clock edge; outputs SHALL be glitch-free, because flush drives asynchronous clears on the pipeline registers.
REQ-018 SHALL sample inputs at a rising edge and hold the resulting outputs for exactly that cycle, so they act at the following falling-edge capture.
REQ-019 SHALL implement states RUN, DIV_WAIT, EXC_FLUSH.
REQ-020 SHALL use this priority in any state: mem_exc, then mem_eret, then mem_branch_taken, then divide, then load-use.
REQ-021 On mem_exc, SHALL assert if_id_flush, id_ex_flush, ex_mem_flush, cp0_exc_write, and pc_redirect with EXC_VECTOR, then enter EXC_FLUSH; any divide count SHALL be discarded.
REQ-022 In EXC_FLUSH, SHALL assert all three flushes for one cycle with no redirect and no cp0_exc_write, then return to RUN.
REQ-023 On mem_eret, SHALL behave as REQ-021 except the redirect address is epc and cp0_exc_write stays low.
REQ-024 On mem_branch_taken, SHALL assert all three flushes and redirect to mem_branch_target for one cycle, with no state change.
REQ-025 In RUN with ex_div high and div_ack low, SHALL enter DIV_WAIT, load counter with DIV_CYCLES-1, and assert pc_stall, if_id_stall, id_ex_stall, ex_mem_flush and div_busy.
REQ-026 In DIV_WAIT, SHALL keep those stalls and flushes, decrementing the counter each cycle.
REQ-027 When the counter reaches 0, SHALL return to RUN with stalls low and set div_ack for one cycle; while div_ack is set, ex_div SHALL be ignored.
REQ-028 Total stall per divide SHALL be exactly DIV_CYCLES cycles.
REQ-029 Load-use hazard, evaluated in RUN only: ex_load, ex_waddr != 0, and the ID instruction reads a matching rs or rt.
REQ-030 On a load-use hazard, SHALL assert pc_stall, if_id_stall and id_ex_flush for one cycle; a hazard on both rs and rt SHALL still give one cycle.
REQ-031 SHALL never assert a stall and a flush on the same register in the same cycle; a flush SHALL override a stall.
REQ-032 pc_redirect_addr SHALL be 0 whenever pc_redirect is low.

Reset
REQ-033 Reset SHALL force state RUN, counter 0, div_ack 0, and every output 0, immediately and independent of clock.
REQ-034 Reset asserted mid-divide or mid-flush SHALL abandon the operation with no residual stall after release.

Structure
REQ-035 State encoding, DIV_CYCLES and EXC_VECTOR SHALL live in the shared CPU package.
REQ-036 The load-use comparator SHALL be a sub-module hazard_detect (purely combinational); the rest SHALL be flat.

Verification
REQ-037 Load-use: ex_load=1, ex_waddr=8, id_rs=8, id_uses_rs=1 -> pc_stall=1, if_id_stall=1, id_ex_flush=1 for exactly 1 cycle.
REQ-038 ex_waddr=0 with matching id_rs=0 -> no stall.
REQ-039 ex_div=1 held -> div_busy and stalls high for 32 consecutive cycles, then low; no re-entry on cycle 33.
REQ-040 Divide at count 10 plus mem_exc=1 -> redirect to 32'h0000_F000, cp0_exc_write for 1 cycle, flushes for 2 cycles, div_busy=0.
REQ-041 mem_eret=1 with epc=32'h0000_0124 -> pc_redirect_addr=32'h0000_0124, cp0_exc_write=0.
REQ-042 mem_branch_taken=1, target 32'h0000_0040, and a simultaneous load-use hazard -> branch flush and redirect only, no stall.
REQ-043 Reset pulse during DIV_WAIT -> all outputs 0 asynchronously; RUN after release.
